// File: rtl/emu_rom_loader_if.sv
// MiSTer hps_io ioctl download bus, shared between the host side and the ROM loader.
interface emu_rom_loader_if;
  logic [15:0] ioctl_index;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_wait;

  modport master (
    output ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr,
    output ioctl_wait
  );
endinterface

// File: rtl/emu_rom_loader.sv
// ioctl download engine: table-driven ROM region split, DIP bank load, completion flags.
// Optional LOADER_CKSUM_EN adds a 16-bit running sum of the bytes written to BRAM.
module emu_rom_loader #(
  parameter int NREG = 12,
  parameter int AW   = 17,
  parameter int NDIP = 2,
  parameter logic [(NREG+1)*AW-1:0] BASE = {
    17'h1A620, 17'h1A600, 17'h1A400, 17'h1A000, 17'h19C00, 17'h19800, 17'h19000,
    17'h18000, 17'h16000, 17'h14000, 17'h10000, 17'h08000, 17'h00000},
  parameter logic [NDIP*8-1:0] DIP_DEF = 16'hF040,
  parameter logic [15:0] ROM_IDX = 16'd0,
  parameter logic [15:0] DIP_IDX = 16'd254
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_INITRST_n,
  emu_rom_loader_if.slave     ioctl,
  input  logic                i_BRAM_BUSY,
  output logic [AW-1:0]       o_BRAM_ADDR,
  output logic [7:0]          o_BRAM_DATA,
  output logic                o_BRAM_WR,
  output logic [NREG-1:0]     o_BRAM_CS,
  output logic [NDIP*8-1:0]   o_DIPSW,
  output logic                o_ROM_DONE,
  output logic                o_DIP_DONE,
  output logic                o_LOAD_DONE,
  output logic                o_ERR,
  output logic [15:0]         o_CKSUM
);

  typedef enum logic [1:0] {S_IDLE, S_ROM, S_DIP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               dl_q, pend_q, pend_d, wr_q, wr_d;
  logic [AW-1:0]      pa_q, pa_d, addr_q, addr_d;
  logic [7:0]         pd_q, pd_d, data_q, data_d;
  logic [NREG-1:0]    pcs_q, pcs_d, cs_q, cs_d;
  logic [NDIP*8-1:0]  dipsw_q, dipsw_d;
  logic               rom_done_q, rom_done_d, dip_done_q, dip_done_d;
  logic               load_done_q, load_done_d, err_q, err_d;

  logic [AW-1:0]      addr_lo;
  logic [26-AW:0]     addr_hi;
  logic [NREG-1:0]    hit_cs;
  logic               in_range, rise, fall, wr_in_rom, accept, issue, enter_rom;
  logic [AW-1:0]      s_addr;
  logic [7:0]         s_data;
  logic [NREG-1:0]    s_cs;

  assign addr_lo = ioctl.ioctl_addr[AW-1:0];
  assign addr_hi = ioctl.ioctl_addr[26:AW];

  // BASE is ascending, so the last matching entry is the highest region containing addr.
  always_comb begin
    hit_cs = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr_lo >= BASE[i*AW +: AW]) begin
        hit_cs    = '0;
        hit_cs[i] = 1'b1;
      end
    end
    in_range = (addr_hi == '0) && (addr_lo >= BASE[0 +: AW]) && (addr_lo < BASE[NREG*AW +: AW]);
  end

  assign rise      = ioctl.ioctl_download & ~dl_q;
  assign fall      = ~ioctl.ioctl_download & dl_q;
  assign wr_in_rom = (state_q == S_ROM) & ioctl.ioctl_wr;
  assign accept    = wr_in_rom & ~pend_q & in_range;
  assign issue     = (pend_q | accept) & ~i_BRAM_BUSY;
  assign enter_rom = (state_q == S_IDLE) & rise & (ioctl.ioctl_index == ROM_IDX);
  // A stalled byte always wins over the bus; a new byte bypasses the slot when the target is free.
  assign s_addr    = pend_q ? pa_q  : addr_lo;
  assign s_data    = pend_q ? pd_q  : ioctl.ioctl_data;
  assign s_cs      = pend_q ? pcs_q : hit_cs;

  assign ioctl.ioctl_wait = (state_q == S_ROM) & (pend_q | i_BRAM_BUSY);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pa_d        = pa_q;
    pd_d        = pd_q;
    pcs_d       = pcs_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cs_d        = cs_q;
    dipsw_d     = dipsw_q;
    rom_done_d  = rom_done_q;
    dip_done_d  = dip_done_q;
    err_d       = err_q;
    load_done_d = rom_done_q & dip_done_q;

    if (wr_in_rom && (pend_q || !in_range)) err_d = 1'b1;

    if (pend_q || accept) begin
      if (i_BRAM_BUSY) begin
        pend_d = 1'b1;
        pa_d   = s_addr;
        pd_d   = s_data;
        pcs_d  = s_cs;
      end else begin
        pend_d = 1'b0;
        wr_d   = 1'b1;
        addr_d = s_addr;
        data_d = s_data;
        cs_d   = s_cs;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (enter_rom) state_d = S_ROM;
        else if (rise && ioctl.ioctl_index == DIP_IDX) state_d = S_DIP;
      end
      S_ROM: begin
        if (fall) begin
          rom_done_d = 1'b1;
          state_d    = dip_done_q ? S_DONE : S_IDLE;
        end
      end
      S_DIP: begin
        if (ioctl.ioctl_wr) begin
          for (int unsigned i = 0; i < NDIP; i++) begin
            if (ioctl.ioctl_addr == 27'(i)) dipsw_d[i*8 +: 8] = ioctl.ioctl_data;
          end
        end
        if (fall) begin
          dip_done_d = 1'b1;
          state_d    = rom_done_q ? S_DONE : S_IDLE;
        end
      end
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      pend_q      <= 1'b0;
      pa_q        <= '0;
      pd_q        <= '0;
      pcs_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '1;
      data_q      <= '1;
      cs_q        <= '0;
      dipsw_q     <= DIP_DEF;
      rom_done_q  <= 1'b0;
      dip_done_q  <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl.ioctl_download;
      pend_q      <= pend_d;
      pa_q        <= pa_d;
      pd_q        <= pd_d;
      pcs_q       <= pcs_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      dipsw_q     <= dipsw_d;
      rom_done_q  <= rom_done_d;
      dip_done_q  <= dip_done_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (enter_rom) cksum_d = '0;
    else if (issue) cksum_d = cksum_q + {8'h00, s_data};
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) cksum_q <= '0;
    else                  cksum_q <= cksum_d;
  end

  assign o_CKSUM = cksum_q;
`else
  assign o_CKSUM = '0;
`endif

  assign o_BRAM_ADDR = addr_q;
  assign o_BRAM_DATA = data_q;
  assign o_BRAM_WR   = wr_q;
  assign o_BRAM_CS   = cs_q;
  assign o_DIPSW     = dipsw_q;
  assign o_ROM_DONE  = rom_done_q;
  assign o_DIP_DONE  = dip_done_q;
  assign o_LOAD_DONE = load_done_q;
  assign o_ERR       = err_q;

endmodule

// File: tb/tb_emu_rom_loader.sv
// Self-checking bench for emu_rom_loader: queue-based behavioural model compared every cycle,
// plus hand-computed expectations for region selects, DIP bank, wait window and completion.
module tb_emu_rom_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy = 1'b0;
  logic [16:0] o_addr;
  logic [7:0]  o_data;
  logic        o_wr;
  logic [11:0] o_cs;
  logic [15:0] o_dipsw;
  logic        o_rom_done, o_dip_done, o_load_done, o_err;
  logic [15:0] o_cksum;

  int checks = 0;
  int failures = 0;

  emu_rom_loader_if bus();

  emu_rom_loader dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST_n (rst_n),
    .ioctl           (bus),
    .i_BRAM_BUSY     (busy),
    .o_BRAM_ADDR     (o_addr),
    .o_BRAM_DATA     (o_data),
    .o_BRAM_WR       (o_wr),
    .o_BRAM_CS       (o_cs),
    .o_DIPSW         (o_dipsw),
    .o_ROM_DONE      (o_rom_done),
    .o_DIP_DONE      (o_dip_done),
    .o_LOAD_DONE     (o_load_done),
    .o_ERR           (o_err),
    .o_CKSUM         (o_cksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ROM = 1, M_DIP = 2, M_DONE = 3;
  localparam int unsigned ROM_END = 32'h1A620;
  int unsigned bases[12] = '{32'h00000, 32'h08000, 32'h10000, 32'h14000, 32'h16000, 32'h18000,
                             32'h19000, 32'h19800, 32'h19C00, 32'h1A000, 32'h1A400, 32'h1A600};

  typedef struct { logic [26:0] a; logic [7:0] d; } wr_t;
  wr_t         q[$];
  int          m_mode;
  logic        m_prev_dl, m_wr, m_rom_done, m_dip_done, m_load, m_err;
  logic [16:0] m_addr;
  logic [7:0]  m_data;
  logic [11:0] m_cs;
  logic [15:0] m_dip, m_ck;

  function automatic int region_of(input logic [26:0] a);
    int r = 0;
    for (int i = 0; i < 12; i++) if (32'(a) >= bases[i]) r = i;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_mode = M_IDLE; m_prev_dl = 1'b0; m_wr = 1'b0;
      m_addr = 17'h1FFFF; m_data = 8'hFF; m_cs = '0; m_dip = 16'hF040;
      m_rom_done = 1'b0; m_dip_done = 1'b0; m_load = 1'b0; m_err = 1'b0; m_ck = '0;
    end else begin
      logic had, ld_next, rise, fall;
      wr_t w;
      had     = q.size() > 0;
      ld_next = m_rom_done & m_dip_done;
      rise    = bus.ioctl_download & ~m_prev_dl;
      fall    = ~bus.ioctl_download & m_prev_dl;
      m_wr    = 1'b0;
      if (m_mode == M_ROM && bus.ioctl_wr) begin
        if (had || 32'(bus.ioctl_addr) >= ROM_END) m_err = 1'b1;
        else q.push_back('{bus.ioctl_addr, bus.ioctl_data});
      end
      if (q.size() > 0 && !busy) begin
        w = q.pop_front();
        m_wr = 1'b1; m_addr = w.a[16:0]; m_data = w.d;
        m_cs = 12'(1) << region_of(w.a);
        m_ck = m_ck + 16'(w.d);
      end
      if (m_mode == M_DIP && bus.ioctl_wr && bus.ioctl_addr < 27'd2)
        m_dip[int'(bus.ioctl_addr)*8 +: 8] = bus.ioctl_data;
      case (m_mode)
        M_IDLE: if (rise) begin
          if (bus.ioctl_index == 16'd0) begin m_mode = M_ROM; m_ck = '0; end
          else if (bus.ioctl_index == 16'd254) m_mode = M_DIP;
        end
        M_ROM: if (fall) begin m_rom_done = 1'b1; m_mode = m_dip_done ? M_DONE : M_IDLE; end
        M_DIP: if (fall) begin m_dip_done = 1'b1; m_mode = m_rom_done ? M_DONE : M_IDLE; end
        default: ;
      endcase
      m_load    = ld_next;
      m_prev_dl = bus.ioctl_download;
    end
  end

  always @(negedge clk) begin
    chk("bram_wr",   32'(o_wr),   32'(m_wr));
    chk("bram_addr", 32'(o_addr), 32'(m_addr));
    chk("bram_data", 32'(o_data), 32'(m_data));
    chk("bram_cs",   32'(o_cs),   32'(m_cs));
    chk("ioctl_wait", 32'(bus.ioctl_wait), 32'(m_mode == M_ROM && (q.size() > 0 || busy)));
    chk("dipsw",     32'(o_dipsw), 32'(m_dip));
    chk("rom_done",  32'(o_rom_done), 32'(m_rom_done));
    chk("dip_done",  32'(o_dip_done), 32'(m_dip_done));
    chk("load_done", 32'(o_load_done), 32'(m_load));
    chk("err",       32'(o_err), 32'(m_err));
`ifdef LOADER_CKSUM_EN
    chk("cksum",     32'(o_cksum), 32'(m_ck));
`else
    chk("cksum_off", 32'(o_cksum), 32'h0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    bus.ioctl_addr = a; bus.ioctl_data = d; bus.ioctl_wr = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [15:0] idx);
    bus.ioctl_index = idx; bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"},  32'(o_addr),  32'h1FFFF);
    chk({tag, "_data"},  32'(o_data),  32'hFF);
    chk({tag, "_wr"},    32'(o_wr),    32'h0);
    chk({tag, "_cs"},    32'(o_cs),    32'h0);
    chk({tag, "_dipsw"}, 32'(o_dipsw), 32'hF040);
    chk({tag, "_flags"}, 32'({o_rom_done, o_dip_done, o_load_done, o_err}), 32'h0);
    chk({tag, "_cksum"}, 32'(o_cksum), 32'h0);
  endtask

  initial begin
    logic [26:0] a;
    int r;
    bus.ioctl_index = '0; bus.ioctl_download = 1'b0; bus.ioctl_addr = '0;
    bus.ioctl_data = '0; bus.ioctl_wr = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // ROM download: checksum bytes, then region boundary writes
    start_dl(16'd0);
    wr_byte(27'h0, 8'hFF); tick();
    wr_byte(27'h1, 8'h02); tick();
    wr_byte(27'h2, 8'h10);
`ifdef LOADER_CKSUM_EN
    chk("cksum_lit", 32'(o_cksum), 32'h0111);
`endif
    tick();
    wr_byte(27'h00000, 8'h00);
    chk("cs0_wr", 32'(o_wr), 32'h1);
    chk("cs0", 32'(o_cs), 32'h001);
    tick();
    wr_byte(27'h1A000, 8'h00);
    chk("cs9", 32'(o_cs), 32'h200);
    chk("cs9_addr", 32'(o_addr), 32'h1A000);
    tick();
    wr_byte(27'h1A600, 8'h00);
    chk("cs11", 32'(o_cs), 32'h800);
    tick();
    for (int i = 0; i < 12; i++) begin
      a = 27'(bases[i]);
      wr_byte(a, a[7:0]);
      if (i > 0) begin wr_byte(a - 27'd1, 8'(a - 27'd1)); end
    end
    wr_byte(27'h1A61F, 8'h1F);
    chk("cs_last", 32'(o_cs), 32'h800);
    tick();
    chk("err_clean", 32'(o_err), 32'h0);

    // busy window: 3 busy clocks at the write, a second write inside the wait window is dropped
    busy = 1'b1;
    wr_byte(27'h00123, 8'hA5);
    chk("wait_w1", 32'(bus.ioctl_wait), 32'h1);
    wr_byte(27'h00456, 8'h5A);
    chk("wait_w2", 32'(bus.ioctl_wait), 32'h1);
    chk("drop_err", 32'(o_err), 32'h1);
    tick();
    busy = 1'b0;
    #1;
    chk("wait_w3", 32'(bus.ioctl_wait), 32'h1);
    chk("no_wr_w3", 32'(o_wr), 32'h0);
    tick();
    chk("wr_4th", 32'(o_wr), 32'h1);
    chk("wr_4th_addr", 32'(o_addr), 32'h00123);
    chk("wr_4th_data", 32'(o_data), 32'hA5);
    tick();

    // reset with a stalled byte pending
    busy = 1'b1;
    wr_byte(27'h00777, 8'h77);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    busy = 1'b0; bus.ioctl_download = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_wr_after_rst", 32'(o_wr), 32'h0);
    end

    // new ROM download: out-of-range address, then randomized traffic
    start_dl(16'd0);
    wr_byte(27'h00010, 8'h10);
    tick();
    wr_byte(27'h1A620, 8'h99);
    chk("oor_no_wr", 32'(o_wr), 32'h0);
    chk("oor_cs", 32'(o_cs), 32'h001);
    chk("oor_err", 32'(o_err), 32'h1);
    tick();
    for (int n = 0; n < 1500; n++) begin
      busy = ($urandom_range(0, 3) == 0);
      bus.ioctl_wr = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 19));
      if (r == 0)      bus.ioctl_addr = 27'h1A620 + 27'($urandom_range(0, 255));
      else if (r == 1) bus.ioctl_addr = (27'($urandom_range(1, 1023)) << 17) | 27'($urandom_range(0, 32'h1A61F));
      else             bus.ioctl_addr = 27'($urandom_range(0, 32'h1A61F));
      bus.ioctl_data = 8'($urandom);
      tick();
    end
    bus.ioctl_wr = 1'b0; busy = 1'b0;
    repeat (3) tick();
    end_dl();
    chk("rom_done", 32'(o_rom_done), 32'h1);
    chk("load_not_yet", 32'(o_load_done), 32'h0);

    // unknown index ignored while idle
    start_dl(16'd5);
    wr_byte(27'h0, 8'h55);
    chk("idx5_no_wr", 32'(o_wr), 32'h0);
    end_dl();

    // DIP bank
    start_dl(16'd254);
    wr_byte(27'h0, 8'h3C); tick();
    wr_byte(27'h1, 8'h0F); tick();
    wr_byte(27'h2, 8'hAA); tick();
    chk("dipsw_lit", 32'(o_dipsw), 32'h0F3C);
    chk("dip_pending", 32'(o_dip_done), 32'h0);
    end_dl();
    chk("dip_done", 32'(o_dip_done), 32'h1);
    chk("load_lag", 32'(o_load_done), 32'h0);
    tick();
    chk("load_done", 32'(o_load_done), 32'h1);

    // absorbing DONE: ROM traffic ignored
    start_dl(16'd0);
    busy = 1'b1;
    wr_byte(27'h00100, 8'h77);
    chk("done_wait", 32'(bus.ioctl_wait), 32'h0);
    busy = 1'b0;
    tick();
    chk("done_no_wr", 32'(o_wr), 32'h0);
    end_dl();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
